mips_exec_ctrl: RTL and testbench
=================================

// Module: mips_exec_ctrl
// PURPOSE
//  Execution sequencer for the single-clock MIPS core on the DE10-Lite board.
//  Turns debounced push-button pulses into a one-cycle clock-enable (CPU_CE) for the core.
//  Modes: single-step, free-run at a divided rate, halt on PC breakpoint.
//  Sits between the button debouncer (pulse outputs) and the core; core and debouncer run on the same 50 MHz clock.
// PARAMETERS
//  RUN_DIV   25_000_000  CLK cycles between CE pulses in RUN (2 instr/s at 50 MHz); legal >= 2
//  DIV_W     25          width of the run divider counter; must hold RUN_DIV-1
//  PC_W      32          PC / breakpoint compare width
// PORTS
//  CLK       in   1     system clock (50 MHz)
//  nRST      in   1     asynchronous reset, active low
//  STEP      in   1     one-CLK pulse: execute one instruction
//  RUN_TOG   in   1     one-CLK pulse: toggle RUN/IDLE
//  BRK_EN    in   1     level: breakpoint compare enabled
//  BRK_PC    in   PC_W  breakpoint address (byte address)
//  PC        in   PC_W  current PC from the core
//  CPU_CE    out  1     one-CLK enable pulse to the core; the core advances one instruction per pulse
//  HALTED    out  1     1 in IDLE or BRK
//  BRK_HIT   out  1     1 while in BRK state
//  STATE     out  2     00 IDLE, 01 STEP, 10 RUN, 11 BRK
//  ICOUNT    out  16    retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (nRST=0, async): STATE=IDLE, CPU_CE=0, HALTED=1, BRK_HIT=0, divider=0, skip=0, ICOUNT=0.
//  All outputs are registered; CPU_CE is never high for two consecutive cycles.
//  IDLE: STEP -> STEP state; RUN_TOG -> RUN (divider loaded with RUN_DIV-1, skip=1).
//  STEP: CPU_CE=1 for exactly one cycle (the cycle after the STEP pulse), then back to IDLE.
//    Latency: STEP pulse at cycle n -> CPU_CE high at n+1 -> STATE=IDLE at n+2.
//    Single step ignores the breakpoint.
//  RUN: divider decrements each cycle; at 0 it reloads RUN_DIV-1 and a fire is due.
//    Fire due AND BRK_EN AND PC==BRK_PC AND skip==0 -> no CE; go to BRK.
//    Otherwise CPU_CE=1 that cycle and skip clears to 0.
//    First fire after entering RUN is exempt (skip=1): resuming at a breakpoint PC steps past it.
//    RUN_TOG -> IDLE immediately; a CE due in that same cycle is suppressed.
//  BRK: HALTED=1, BRK_HIT=1.
//    STEP -> STEP state (executes the breakpoint instruction).
//    RUN_TOG -> RUN with skip=1.
//  Simultaneous STEP and RUN_TOG: RUN_TOG wins, STEP is dropped (all states).
//  STEP while in RUN or STEP: ignored.
//  BRK_EN/BRK_PC changed mid-run: takes effect at the next fire.
//  PC compare is full PC_W bits, equality only.
//  Reset mid-operation: a CE pulse in flight is cut (async clear); no pending step survives reset.
// CONFIGURATION
//  MIPS_EXEC_ICOUNT_EN defined: ICOUNT increments on every cycle CPU_CE=1 and wraps at
//    16'hFFFF -> 16'h0000; cleared only by reset.
//  MIPS_EXEC_ICOUNT_EN undefined: counter not built; ICOUNT tied to 16'h0000.
// TESTING  (RUN_DIV=4 for sim)
//  1. Reset, then one STEP pulse -> CPU_CE high exactly 1 cycle, at the cycle after STEP.
//     STATE 00->01->00; HALTED back to 1.
//  2. RUN_TOG, then hold for 20 cycles -> CE every 4th cycle (5 pulses), HALTED=0, STATE=10.
//     Then RUN_TOG -> STATE=00 and no further CE.
//  3. BRK_EN=1, BRK_PC=32'h0000_000C, PC model +4 per CE from 0, RUN.
//     -> CE at PC 0,4,8; at PC=C no CE; STATE=11, BRK_HIT=1.
//  4. From test 3, RUN_TOG -> next fire issues CE at PC=C, continues to 10,14.
//     A STEP from BRK instead gives exactly one CE then IDLE.
//  5. STEP and RUN_TOG in the same cycle in IDLE -> RUN entered, no immediate CE.
//     Assert nRST low mid-CE -> CPU_CE drops in the same cycle, STATE=00.
//  6. With MIPS_EXEC_ICOUNT_EN: preload via 65535 steps (or force) then one more step -> ICOUNT=0.
//     Without the macro: ICOUNT=0 throughout.

Source files
------------

// File: rtl/mips_exec_ctrl.sv
// Execution sequencer: turns debounced button pulses into a one-cycle CE for the MIPS core.
// Optional retired-instruction counter is built when MIPS_EXEC_ICOUNT_EN is defined.
module mips_exec_ctrl #(
  parameter int RUN_DIV = 25_000_000,
  parameter int DIV_W   = 25,
  parameter int PC_W    = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            STEP,
  input  logic            RUN_TOG,
  input  logic            BRK_EN,
  input  logic [PC_W-1:0] BRK_PC,
  input  logic [PC_W-1:0] PC,
  output logic            CPU_CE,
  output logic            HALTED,
  output logic            BRK_HIT,
  output logic [1:0]      STATE,
  output logic [15:0]     ICOUNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_RUN  = 2'b10,
    S_BRK  = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(RUN_DIV - 1);

  state_t           state_q, state_d;
  logic             ce_q, ce_d;
  logic             halted_q, halted_d;
  logic             brk_hit_q, brk_hit_d;
  logic             skip_q, skip_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             fire_due;
  logic             brk_match;

  assign fire_due  = (div_q == '0);
  assign brk_match = BRK_EN && (PC == BRK_PC);

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    div_d   = div_q;
    skip_d  = skip_q;
    unique case (state_q)
      S_IDLE, S_BRK: begin
        // RUN_TOG has priority over a coincident STEP
        if (RUN_TOG) begin
          state_d = S_RUN;
          div_d   = RELOAD;
          skip_d  = 1'b1;
        end else if (STEP) begin
          state_d = S_STEP;
          ce_d    = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (RUN_TOG) begin
          state_d = S_IDLE;
        end else if (fire_due) begin
          div_d = RELOAD;
          // skip lets a resume from a breakpoint PC execute that instruction
          if (brk_match && !skip_q) begin
            state_d = S_BRK;
          end else begin
            ce_d   = 1'b1;
            skip_d = 1'b0;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    halted_d  = (state_d == S_IDLE) || (state_d == S_BRK);
    brk_hit_d = (state_d == S_BRK);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      ce_q      <= 1'b0;
      halted_q  <= 1'b1;
      brk_hit_q <= 1'b0;
      skip_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      ce_q      <= ce_d;
      halted_q  <= halted_d;
      brk_hit_q <= brk_hit_d;
      skip_q    <= skip_d;
      div_q     <= div_d;
    end
  end

  assign CPU_CE  = ce_q;
  assign HALTED  = halted_q;
  assign BRK_HIT = brk_hit_q;
  assign STATE   = state_q;

`ifdef MIPS_EXEC_ICOUNT_EN
  logic [15:0] icount_q, icount_d;

  always_comb begin
    icount_d = icount_q;
    if (ce_q) icount_d = icount_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) icount_q <= 16'h0000;
    else       icount_q <= icount_d;
  end

  assign ICOUNT = icount_q;
`else
  assign ICOUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Scoreboard bench for mips_exec_ctrl: expected CE PCs are queued when stimulus is driven
// and popped by a monitor whenever CPU_CE is observed.
module tb_mips_exec_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        STEP = 1'b0;
  logic        RUN_TOG = 1'b0;
  logic        BRK_EN = 1'b0;
  logic [31:0] BRK_PC = 32'h0;
  logic [31:0] PC;
  logic        CPU_CE;
  logic        HALTED;
  logic        BRK_HIT;
  logic [1:0]  STATE;
  logic [15:0] ICOUNT;

  logic [31:0] pc_m = 32'h0;
  logic        pc_clr = 1'b0;
  logic        prev_ce = 1'b0;
  int          ce_seen = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc[$];

  mips_exec_ctrl #(.RUN_DIV(4), .DIV_W(3), .PC_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .STEP(STEP), .RUN_TOG(RUN_TOG),
    .BRK_EN(BRK_EN), .BRK_PC(BRK_PC), .PC(PC),
    .CPU_CE(CPU_CE), .HALTED(HALTED), .BRK_HIT(BRK_HIT),
    .STATE(STATE), .ICOUNT(ICOUNT)
  );

  always #5 CLK = ~CLK;

  // Core stand-in: PC advances by 4 for every CE
  always @(posedge CLK) begin
    if (!nRST || pc_clr) pc_m <= 32'h0;
    else if (CPU_CE)     pc_m <= pc_m + 32'd4;
  end
  assign PC = pc_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!nRST) begin
      prev_ce <= 1'b0;
      ce_seen <= 0;
    end else begin
      if (CPU_CE) begin
        check("ce_gap", {31'd0, prev_ce}, 32'd0);
        check("ce_queued", {31'd0, exp_pc.size() != 0}, 32'd1);
        if (exp_pc.size() != 0) check("ce_pc", PC, exp_pc.pop_front());
        ce_seen <= ce_seen + 1;
      end
      prev_ce <= CPU_CE;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_step();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
  endtask

  task automatic pulse_run();
    RUN_TOG = 1'b1;
    tick();
    RUN_TOG = 1'b0;
  endtask

  task automatic clear_pc();
    pc_clr = 1'b1;
    tick();
    pc_clr = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
    int n = 0;
    while (STATE !== s && n < lim) begin
      tick();
      n++;
    end
    check(tag, {30'd0, STATE}, {30'd0, s});
  endtask

  initial begin
    #12;
    check("rst_state", {30'd0, STATE}, 32'd0);
    check("rst_ce", {31'd0, CPU_CE}, 32'd0);
    check("rst_halted", {31'd0, HALTED}, 32'd1);
    check("rst_brk", {31'd0, BRK_HIT}, 32'd0);
    check("rst_icount", {16'd0, ICOUNT}, 32'd0);
    nRST = 1'b1;
    tick();
    tick();

    // Single step
    exp_pc.push_back(32'h0);
    do_step();
    check("t1_ce", {31'd0, CPU_CE}, 32'd1);
    check("t1_state_step", {30'd0, STATE}, 32'd1);
    check("t1_halted_lo", {31'd0, HALTED}, 32'd0);
    tick();
    check("t1_ce_off", {31'd0, CPU_CE}, 32'd0);
    check("t1_state_idle", {30'd0, STATE}, 32'd0);
    check("t1_halted", {31'd0, HALTED}, 32'd1);

    // Free run: 20 cycles give 5 CEs
    clear_pc();
    for (int i = 0; i < 5; i++) exp_pc.push_back(32'(i * 4));
    pulse_run();
    check("t2_state_run", {30'd0, STATE}, 32'd2);
    check("t2_halted", {31'd0, HALTED}, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("t2_still_run", {30'd0, STATE}, 32'd2);
    pulse_run();
    check("t2_stop_state", {30'd0, STATE}, 32'd0);
    check("t2_stop_ce", {31'd0, CPU_CE}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("t2_q_empty", exp_pc.size(), 32'd0);

    // Breakpoint at 0xC
    clear_pc();
    BRK_EN = 1'b1;
    BRK_PC = 32'h0000_000C;
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h8);
    pulse_run();
    wait_state(2'b11, 40, "t3_brk_state");
    check("t3_brk_hit", {31'd0, BRK_HIT}, 32'd1);
    check("t3_halted", {31'd0, HALTED}, 32'd1);
    check("t3_pc", PC, 32'h0000_000C);
    check("t3_q_empty", exp_pc.size(), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("t3_brk_stays", {30'd0, STATE}, 32'd3);

    // Resume steps past the breakpoint; stop coincides with a due fire
    exp_pc.push_back(32'h0C);
    exp_pc.push_back(32'h10);
    exp_pc.push_back(32'h14);
    pulse_run();
    check("t4_brk_clr", {31'd0, BRK_HIT}, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    pulse_run();
    check("t4_stop_state", {30'd0, STATE}, 32'd0);
    check("t4_stop_ce", {31'd0, CPU_CE}, 32'd0);
    tick();
    tick();
    check("t4_q_empty", exp_pc.size(), 32'd0);
    check("t4_pc", PC, 32'h18);

    // Step out of a breakpoint
    BRK_PC = 32'h1C;
    exp_pc.push_back(32'h18);
    pulse_run();
    wait_state(2'b11, 40, "t4_brk2_state");
    exp_pc.push_back(32'h1C);
    do_step();
    check("t4_step_ce", {31'd0, CPU_CE}, 32'd1);
    check("t4_step_state", {30'd0, STATE}, 32'd1);
    tick();
    check("t4_step_ce_off", {31'd0, CPU_CE}, 32'd0);
    check("t4_step_idle", {30'd0, STATE}, 32'd0);
    check("t4_step_brkhit", {31'd0, BRK_HIT}, 32'd0);
    check("t4_q_empty2", exp_pc.size(), 32'd0);

    // Simultaneous STEP and RUN_TOG, then reset during a CE
    BRK_EN = 1'b0;
    STEP = 1'b1;
    RUN_TOG = 1'b1;
    tick();
    STEP = 1'b0;
    RUN_TOG = 1'b0;
    check("t5_run", {30'd0, STATE}, 32'd2);
    check("t5_no_ce", {31'd0, CPU_CE}, 32'd0);
    begin
      int n = 0;
      while (CPU_CE !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
    end
    check("t5_ce_seen", {31'd0, CPU_CE}, 32'd1);
    nRST = 1'b0;
    #1;
    check("t5_rst_ce", {31'd0, CPU_CE}, 32'd0);
    check("t5_rst_state", {30'd0, STATE}, 32'd0);
    check("t5_rst_halted", {31'd0, HALTED}, 32'd1);
    check("t5_rst_icount", {16'd0, ICOUNT}, 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    tick();
    check("t5_post_state", {30'd0, STATE}, 32'd0);

    // Instruction counter
    for (int i = 0; i < 3; i++) begin
      exp_pc.push_back(32'(i * 4));
      do_step();
      tick();
    end
    tick();
`ifdef MIPS_EXEC_ICOUNT_EN
    check("t6_icount", {16'd0, ICOUNT}, 32'(ce_seen));
    check("t6_icount3", {16'd0, ICOUNT}, 32'd3);
    force dut.icount_q = 16'hFFFF;
    #1;
    release dut.icount_q;
    #1;
    check("t6_preload", {16'd0, ICOUNT}, 32'h0000_FFFF);
    exp_pc.push_back(32'hC);
    do_step();
    tick();
    check("t6_wrap", {16'd0, ICOUNT}, 32'd0);
`else
    check("t6_icount_off", {16'd0, ICOUNT}, 32'd0);
`endif
    check("t6_q_empty", exp_pc.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
